// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute sequencer for the 8-bit CPU
// Optional illegal-opcode trap (adds illegal_op port): define ILLEGAL_TRAP_EN.
module cpu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic [PC_W-1:0] rom_addr,
    output logic            rom_req,
    input  logic [7:0]      rom_data,
    input  logic            rom_valid,
    output logic [15:0]     instr,
    input  logic [3:0]      opcode,
    input  logic            zero_flag,
    output logic            alu_en,
    output logic            rf_we,
    output logic [1:0]      rf_wsel,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ready,
`ifdef ILLEGAL_TRAP_EN
    output logic            illegal_op,
`endif
    output logic            halted
);

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_ORR = 4'h3;
    localparam logic [3:0] OP_XORR = 4'h4, OP_LD = 4'h5, OP_ST = 4'h6, OP_JMP = 4'h7;
    localparam logic [3:0] OP_BEQ = 4'h8, OP_LDI = 4'h9, OP_NOTI = 4'hA, OP_HLT = 4'hB;

    localparam logic [1:0] WSEL_ALU = 2'd0, WSEL_MEM = 2'd1, WSEL_IMM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_LO, S_FETCH_HI, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            is_alu;

    assign target   = PC_W'(instr[15:8]);
    assign rom_addr = (state == S_FETCH_HI) ? pc + PC_W'(1) : pc;
    assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ORR) ||
                      (opcode == OP_XORR) || (opcode == OP_NOTI);

    // Strobes are registered: each transition loads the outputs of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            rom_req <= 1'b0;
            alu_en  <= 1'b0;
            rf_we   <= 1'b0;
            rf_wsel <= WSEL_ALU;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            halted  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            alu_en <= 1'b0;
            rf_we  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state   <= S_FETCH_LO;
                        rom_req <= 1'b1;
                    end
                end
                S_FETCH_LO: begin
                    if (rom_valid) begin
                        instr[7:0] <= rom_data;
                        state      <= S_FETCH_HI;
                    end
                end
                S_FETCH_HI: begin
                    if (rom_valid) begin
                        instr[15:8] <= rom_data;
                        rom_req     <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    pc     <= pc + PC_W'(2);
                    alu_en <= is_alu;
                    state  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_alu) begin
                        rf_we   <= 1'b1;
                        rf_wsel <= WSEL_ALU;
                        state   <= S_WRITEBACK;
                    end else begin
                        case (opcode)
                            OP_LDI: begin
                                rf_we   <= 1'b1;
                                rf_wsel <= WSEL_IMM;
                                state   <= S_WRITEBACK;
                            end
                            OP_LD, OP_ST: begin
                                mem_req <= 1'b1;
                                mem_we  <= (opcode == OP_ST);
                                state   <= S_MEM;
                            end
                            OP_JMP: begin
                                pc      <= target;
                                rom_req <= 1'b1;
                                state   <= S_FETCH_LO;
                            end
                            OP_BEQ: begin
                                if (zero_flag) pc <= target;
                                rom_req <= 1'b1;
                                state   <= S_FETCH_LO;
                            end
                            OP_HLT: begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end
`ifdef ILLEGAL_TRAP_EN
                            4'hC, 4'hD, 4'hE, 4'hF: begin
                                halted     <= 1'b1;
                                illegal_op <= 1'b1;
                                state      <= S_HALT;
                            end
`endif
                            default: begin
                                rom_req <= 1'b1;
                                state   <= S_FETCH_LO;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (mem_we) begin
                            rom_req <= 1'b1;
                            state   <= S_FETCH_LO;
                        end else begin
                            rf_we   <= 1'b1;
                            rf_wsel <= WSEL_MEM;
                            state   <= S_WRITEBACK;
                        end
                    end
                end
                S_WRITEBACK: begin
                    rom_req <= 1'b1;
                    state   <= S_FETCH_LO;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized bench for cpu_sequencer against an instruction-level model
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run, rom_req, rom_valid, zero_flag;
    logic        alu_en, rf_we, mem_req, mem_we, mem_ready, halted;
    logic [7:0]  rom_addr, rom_data;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [1:0]  rf_wsel;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    always #5 clk = ~clk;
    assign opcode = instr[7:4];

    cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_data(rom_data), .rom_valid(rom_valid),
        .instr(instr), .opcode(opcode), .zero_flag(zero_flag),
        .alu_en(alu_en), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
`ifdef ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .halted(halted)
    );

    typedef struct packed {
        logic [7:0]  rom_addr;
        logic        rom_req;
        logic        alu_en;
        logic        rf_we;
        logic [1:0]  rf_wsel;
        logic        mem_req;
        logic        mem_we;
        logic        halted;
        logic        illegal;
        logic        instr_chk;
        logic [15:0] instr;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  rom [256];
    logic [7:0]  m_pc;
    logic        m_halted, m_illegal;
    logic [15:0] m_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rom_addr", 32'(rom_addr), 32'(e.rom_addr));
            chk("rom_req", 32'(rom_req), 32'(e.rom_req));
            chk("alu_en", 32'(alu_en), 32'(e.alu_en));
            chk("rf_we", 32'(rf_we), 32'(e.rf_we));
            chk("mem_req", 32'(mem_req), 32'(e.mem_req));
            chk("halted", 32'(halted), 32'(e.halted));
            if (e.rf_we) chk("rf_wsel", 32'(rf_wsel), 32'(e.rf_wsel));
            if (e.mem_req) chk("mem_we", 32'(mem_we), 32'(e.mem_we));
            if (e.instr_chk) chk("instr", 32'(instr), 32'(e.instr));
`ifdef ILLEGAL_TRAP_EN
            chk("illegal_op", 32'(illegal_op), 32'(e.illegal));
`endif
        end
    end

    function automatic exp_t base_exp();
        exp_t e;
        e = '0;
        e.rom_addr = m_pc;
        e.halted   = m_halted;
        e.illegal  = m_illegal;
        return e;
    endfunction

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        run       = 1'($urandom);
        rom_valid = 1'($urandom);
        rom_data  = 8'($urandom);
        mem_ready = 1'($urandom);
        zero_flag = 1'($urandom);
    endtask

    // One instruction expanded from the latency rules: fetch lo/hi (+waits), decode, execute, mem (+waits), writeback.
    task automatic run_instr(input logic [15:0] ins, input logic zf, input int wlo, input int whi,
                             input int wmem, output int ncyc);
        logic [3:0] op;
        logic [7:0] hi_addr;
        logic       is_alu, is_mem, trap;
        exp_t       e;
        op      = ins[7:4];
        hi_addr = m_pc + 8'd1;
        is_alu  = (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hA});
        is_mem  = (op == 4'h5) || (op == 4'h6);
`ifdef ILLEGAL_TRAP_EN
        trap = (op >= 4'hC);
`else
        trap = 1'b0;
`endif
        rom[m_pc]    = ins[7:0];
        rom[hi_addr] = ins[15:8];
        ncyc = 0;
        for (int i = 0; i <= wlo; i++) begin
            noise();
            rom_valid = (i == wlo);
            if (rom_valid) rom_data = rom[m_pc];
            e = base_exp(); e.rom_req = 1'b1;
            cyc(e); ncyc++;
        end
        for (int i = 0; i <= whi; i++) begin
            noise();
            rom_valid = (i == whi);
            if (rom_valid) rom_data = rom[hi_addr];
            e = base_exp(); e.rom_req = 1'b1; e.rom_addr = hi_addr;
            cyc(e); ncyc++;
        end
        m_instr = ins;
        noise();
        e = base_exp(); e.instr_chk = 1'b1; e.instr = ins;
        cyc(e); ncyc++;
        m_pc = m_pc + 8'd2;
        noise();
        zero_flag = zf;
        e = base_exp(); e.instr_chk = 1'b1; e.instr = ins; e.alu_en = is_alu;
        cyc(e); ncyc++;
        if (op == 4'h7 || (op == 4'h8 && zf)) m_pc = ins[15:8];
        if (op == 4'hB || trap) begin
            m_halted  = 1'b1;
            m_illegal = trap;
        end
        if (is_mem) begin
            for (int i = 0; i <= wmem; i++) begin
                noise();
                mem_ready = (i == wmem);
                e = base_exp(); e.mem_req = 1'b1; e.mem_we = (op == 4'h6);
                e.instr_chk = 1'b1; e.instr = ins;
                cyc(e); ncyc++;
            end
        end
        if (is_alu || op == 4'h9 || op == 4'h5) begin
            noise();
            e = base_exp(); e.rf_we = 1'b1; e.instr_chk = 1'b1; e.instr = ins;
            e.rf_wsel = is_alu ? 2'd0 : (op == 4'h9 ? 2'd2 : 2'd1);
            cyc(e); ncyc++;
        end
    endtask

    task automatic halt_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            noise();
            e = base_exp(); e.instr_chk = 1'b1; e.instr = m_instr;
            cyc(e);
        end
    endtask

    task automatic reset_and_start();
        exp_t e;
        rst_n = 1'b0; run = 1'b0;
        m_pc = 8'h00; m_halted = 1'b0; m_illegal = 1'b0; m_instr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rom_req", 32'(rom_req), 32'h0);
        chk("reset_rom_addr", 32'(rom_addr), 32'h00);
        chk("reset_instr", 32'(instr), 32'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            noise();
            run = (i == 2);
            e = base_exp(); e.instr_chk = 1'b1; e.instr = 16'h0000;
            cyc(e);
        end
    endtask

    int         n;
    logic [3:0] op;

    initial begin
        rst_n = 1'b0;
        noise();
        reset_and_start();

        run_instr(16'h0010, 1'b0, 0, 0, 0, n);
        chk("lat_add", 32'(n), 32'd5);
        #2 chk("pc_after_add", 32'(rom_addr), 32'h02);
        run_instr(16'h5A9C, 1'b0, 0, 0, 0, n);
        chk("lat_ldi", 32'(n), 32'd5);
        #2 chk("instr_ldi", 32'(instr), 32'h5A9C);
        run_instr(16'h3350, 1'b0, 0, 0, 3, n);
        chk("lat_ld_wait3", 32'(n), 32'd9);
        run_instr(16'h4080, 1'b1, 1, 2, 0, n);
        #2 chk("beq_taken", 32'(rom_addr), 32'h40);
        run_instr(16'h4080, 1'b0, 0, 0, 0, n);
        chk("lat_beq", 32'(n), 32'd4);
        #2 chk("beq_not_taken", 32'(rom_addr), 32'h42);
        run_instr(16'hFE70, 1'b0, 0, 0, 0, n);
        #2 chk("jmp_fe", 32'(rom_addr), 32'hFE);
        run_instr(16'h0000, 1'b0, 0, 0, 0, n);
        #2 chk("pc_wrap", 32'(rom_addr), 32'h00);
        run_instr(16'h1160, 1'b0, 0, 0, 0, n);
        chk("lat_st", 32'(n), 32'd5);

        for (int k = 0; k < 150; k++) begin
            do op = 4'($urandom);
`ifdef ILLEGAL_TRAP_EN
            while (op >= 4'hB);
`else
            while (op == 4'hB);
`endif
            run_instr({8'($urandom), op, 4'($urandom)}, 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 3), n);
        end

        run_instr(16'h00E0, 1'b0, 0, 0, 0, n);
`ifdef ILLEGAL_TRAP_EN
        halt_cycles(2);
        chk("illegal_op", 32'(illegal_op), 32'h1);
`else
        chk("lat_illegal_nop", 32'(n), 32'd4);
        run_instr(16'h00B0, 1'b0, 0, 0, 0, n);
`endif
        halt_cycles(12);
        chk("halted_sticky", 32'(halted), 32'h1);

        reset_and_start();
        begin
            exp_t e;
            rom[8'h00] = 8'h10;
            noise(); rom_valid = 1'b1; rom_data = rom[8'h00];
            e = base_exp(); e.rom_req = 1'b1;
            cyc(e);
            for (int i = 0; i < 2; i++) begin
                noise(); rom_valid = 1'b0;
                e = base_exp(); e.rom_req = 1'b1; e.rom_addr = 8'h01;
                cyc(e);
            end
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_rom_req", 32'(rom_req), 32'h0);
        chk("midreset_rom_addr", 32'(rom_addr), 32'h00);
        chk("midreset_instr", 32'(instr), 32'h0000);
        chk("midreset_halted", 32'(halted), 32'h0);
        reset_and_start();
        run_instr(16'h0010, 1'b0, 0, 0, 0, n);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name:
cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit CPU.
- Fetches a 16-bit instruction as two bytes from the 8-bit ROM and holds it in an instruction register.
- The instruction register drives the instruction decoder, which returns the 4-bit opcode.
- Sequences the ALU, data memory and register-file writeback, and maintains the program counter.

Parameters:
PC_W, 8, program counter / ROM address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  leave IDLE and start executing
rom_addr  output  PC_W  ROM byte address
rom_req  output  1  ROM read request
rom_data  input  8  ROM read byte
rom_valid  input  1  rom_data valid this cycle
instr  output  16  instruction register; [7:4] opcode, [3:2] dest, [1] rs1, [0] rs2, [15:8] imm8/address
opcode  input  4  decoded opcode from decoder (combinational from instr)
zero_flag  input  1  ALU zero result flag
alu_en  output  1  ALU operation strobe
rf_we  output  1  register-file write enable
rf_wsel  output  2  writeback source: 0 ALU, 1 memory, 2 imm8
mem_req  output  1  data-memory request
mem_we  output  1  1 = store, 0 = load (valid with mem_req)
halted  output  1  HLT executed

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously forces: state=IDLE, pc=RESET_PC, instr=0, all strobes 0, halted=0.
  - Reset mid-instruction abandons the instruction; no partial write survives.
- Outputs:
  - Control outputs are Moore-decoded from the state register.
  - pc and instr are registers.
  - rom_addr = pc in FETCH_LO, pc+1 in FETCH_HI, pc otherwise.
- States and transitions:
  - IDLE: no strobes. run=1 -> FETCH_LO.
  - FETCH_LO: rom_req=1. On rom_valid, instr[7:0]<=rom_data -> FETCH_HI. Otherwise wait indefinitely.
  - FETCH_HI: rom_req=1. On rom_valid, instr[15:8]<=rom_data -> DECODE.
  - DECODE: one cycle; pc<=pc+2 modulo 2^PC_W (0xFE wraps to 0x00) -> EXECUTE.
  - EXECUTE (one cycle), by opcode:
    - ADD(1), SUB(2), ORR(3), XORR(4), NOTI(A): alu_en=1 -> WRITEBACK, rf_wsel=0.
    - LDI(9): -> WRITEBACK, rf_wsel=2.
    - LD(5), ST(6): -> MEM.
    - JMP(7): pc<=imm8 (zero-extended) -> FETCH_LO.
    - BEQ(8): if zero_flag, pc<=imm8; else pc unchanged -> FETCH_LO.
    - NOP(0): -> FETCH_LO.
    - HLT(B): -> HALT.
    - C–F: see Optional Feature.
  - MEM:
    - mem_req=1; mem_we=1 for ST.
    - Hold until mem_ready=1; mem_req stays high while waiting.
    - On ready: LD -> WRITEBACK (rf_wsel=1); ST -> FETCH_LO.
  - WRITEBACK: rf_we=1 for exactly one cycle; rf_wsel held from EXECUTE -> FETCH_LO.
  - HALT: halted=1, all strobes 0. Absorbing; exit only via rst_n. run ignored.
- Ignored inputs:
  - rom_valid outside FETCH_LO/FETCH_HI.
  - mem_ready outside MEM.
- Latency with zero-wait ROM/memory (valid/ready tied 1), measured FETCH_LO entry to next FETCH_LO entry:
  - NOP, JMP, BEQ, ST-less: 4 cycles.
  - ALU ops, LDI: 5 cycles.
  - ST: 5 cycles.
  - LD: 6 cycles.
  - Each ROM/memory wait cycle adds 1.
- Invariants:
  - At most one of alu_en/rf_we/mem_req is high in any cycle.
  - rf_we is never high outside WRITEBACK.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: opcodes C–F in EXECUTE -> HALT, and the 1-bit output illegal_op is set with halted. illegal_op resets to 0 and is cleared only by rst_n.
- Undefined: opcodes C–F execute as NOP, and the illegal_op port is absent.

Test Plan:
1. Reset then run=1; ROM holds 0x0010 at 0x00 (ADD dest0), valid tied 1 -> rom_addr 0x00,0x01; alu_en high cycle 4; rf_we high with rf_wsel=0 in cycle 5; pc=0x02.
2. LDI 0x5A9C at 0x02 -> instr=0x5A9C, rf_we with rf_wsel=2, no mem_req; then LD with mem_ready delayed 3 cycles -> mem_req high 4 cycles, mem_we=0, rf_wsel=1 writeback, 9-cycle instruction.
3. BEQ imm 0x40 with zero_flag=1 -> next rom_addr 0x40; repeat with zero_flag=0 -> next rom_addr pc+2.
4. JMP to 0xFE, then NOP at 0xFE -> fetch addresses 0xFE,0xFF, pc wraps to 0x00.
5. HLT -> halted=1, no further rom_req despite run toggling; rst_n low mid-FETCH_HI with rom_valid stalled -> immediate IDLE, pc=RESET_PC, instr=0.
6. Opcode 0xE: with ILLEGAL_TRAP_EN -> halted=1, illegal_op=1; without -> treated as NOP, pc advances by 2.
